// File: rtl/decode_ctrl_stage.sv
// Decode/control stage: turns a fetched 16-bit instruction into a registered
// control bundle, tracks the exception flow (SIIC/RTI) and the halted state,
// and counts illegal instructions.
module decode_ctrl_stage #(
    parameter int unsigned     PC_W         = 16,
    parameter logic [PC_W-1:0] EXC_VEC      = 16'h0002,
    parameter bit              ENABLE_EXC   = 1'b1,
    parameter logic [31:0]     ILLEGAL_MASK = 32'h0,
    parameter int unsigned     CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            halt_ext,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_reg_wrt,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_branch,
    output logic            out_jmp,
    output logic            out_jmp_reg,
    output logic [4:0]      out_alu_op,
    output logic            out_halt,
    output logic            out_err,
    output logic            out_redirect,
    output logic [PC_W-1:0] out_redirect_pc,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StExc    = 2'b01,
        StHalted = 2'b10
    } state_e;

    localparam logic [4:0] OpHalt = 5'b00000;
    localparam logic [4:0] OpSiic = 5'b00010;
    localparam logic [4:0] OpRti  = 5'b00011;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  epc_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             out_valid_q, out_valid_d;

    logic [4:0] op;
    logic       accept;
    logic       is_siic, is_rti, illegal, siic_ok, rti_ok, do_halt;
    logic       dec_reg_wrt, dec_mem_rd, dec_mem_wr, dec_branch, dec_jmp, dec_jmp_reg;

    assign op     = in_instr[15:11];
    assign accept = in_valid && in_ready && !flush;

    // Instruction classification; illegal ones must not touch any architectural state.
    always_comb begin
        is_siic = (op == OpSiic);
        is_rti  = (op == OpRti);
        illegal = ILLEGAL_MASK[op]
                  || ((is_siic || is_rti) && !ENABLE_EXC)
                  || (is_siic && state_q == StExc)
                  || (is_rti && state_q == StRun);
        siic_ok = is_siic && !illegal;
        rti_ok  = is_rti && !illegal;
        // External halt applies to whatever instruction is accepted alongside it.
        do_halt = halt_ext || (op == OpHalt && !illegal);
    end

    // Control-bit decode, all write/branch/jump bits suppressed for illegal instructions.
    always_comb begin
        dec_reg_wrt = (op[4:2] == 3'b010) || (op[4:2] == 3'b101) || (op[4:3] == 2'b11)
                      || (op inside {5'b10001, 5'b10010, 5'b10011, 5'b00110, 5'b00111});
        dec_mem_rd  = (op == 5'b10001);
        dec_mem_wr  = (op == 5'b10000) || (op == 5'b10011);
        dec_branch  = (op[4:2] == 3'b011);
        dec_jmp     = (op == 5'b00100) || (op == 5'b00110);
        dec_jmp_reg = (op == 5'b00101) || (op == 5'b00111);
        if (illegal) begin
            dec_reg_wrt = 1'b0;
            dec_mem_rd  = 1'b0;
            dec_mem_wr  = 1'b0;
            dec_branch  = 1'b0;
            dec_jmp     = 1'b0;
            dec_jmp_reg = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only accepted instructions move the state; HALTED is sticky.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (do_halt) begin
                state_d = StHalted;
            end else if (siic_ok) begin
                state_d = StExc;
            end else if (rti_ok) begin
                state_d = StRun;
            end
        end
    end

    // FSM outputs: handshake and visible state.
    always_comb begin
        in_ready = (state_q != StHalted) && (!out_valid_q || out_ready);
        state    = state_q;
    end

    // Output valid: flush wins, then a new accept, then drain on consume.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control bundle, exception PC and illegal counter; bundle loads only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_reg_wrt     <= 1'b0;
            out_mem_rd      <= 1'b0;
            out_mem_wr      <= 1'b0;
            out_branch      <= 1'b0;
            out_jmp         <= 1'b0;
            out_jmp_reg     <= 1'b0;
            out_alu_op      <= 5'b0;
            out_halt        <= 1'b0;
            out_err         <= 1'b0;
            out_redirect    <= 1'b0;
            out_redirect_pc <= '0;
            epc_q           <= '0;
            err_cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_reg_wrt     <= dec_reg_wrt;
                out_mem_rd      <= dec_mem_rd;
                out_mem_wr      <= dec_mem_wr;
                out_branch      <= dec_branch;
                out_jmp         <= dec_jmp;
                out_jmp_reg     <= dec_jmp_reg;
                out_alu_op      <= op;
                out_halt        <= do_halt;
                out_err         <= illegal;
                out_redirect    <= (siic_ok || rti_ok) && !do_halt;
                out_redirect_pc <= siic_ok ? EXC_VEC : (rti_ok ? epc_q : '0);
                if (siic_ok) begin
                    epc_q <= in_pc;
                end
                if (illegal && err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: a default instance plus one with
// opcode 01000 masked illegal and a 2-bit error counter, sharing stimulus.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, halt_ext, flush, out_valid, out_ready;
    logic [15:0] in_instr, in_pc;
    logic        out_reg_wrt, out_mem_rd, out_mem_wr, out_branch, out_jmp, out_jmp_reg;
    logic [4:0]  out_alu_op;
    logic        out_halt, out_err, out_redirect;
    logic [15:0] out_redirect_pc;
    logic [7:0]  err_cnt;
    logic [1:0]  state;

    logic        m_in_ready, m_out_valid;
    logic        m_reg_wrt, m_mem_rd, m_mem_wr, m_branch, m_jmp, m_jmp_reg;
    logic [4:0]  m_alu_op;
    logic        m_halt, m_err, m_redirect;
    logic [15:0] m_redirect_pc;
    logic [1:0]  m_err_cnt;
    logic [1:0]  m_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .halt_ext(halt_ext), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_reg_wrt(out_reg_wrt),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
        .out_jmp(out_jmp), .out_jmp_reg(out_jmp_reg), .out_alu_op(out_alu_op),
        .out_halt(out_halt), .out_err(out_err), .out_redirect(out_redirect),
        .out_redirect_pc(out_redirect_pc), .err_cnt(err_cnt), .state(state)
    );

    decode_ctrl_stage #(
        .ILLEGAL_MASK(32'h0000_0100),
        .CNT_W       (2)
    ) dut_mask (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .halt_ext(halt_ext), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_reg_wrt(m_reg_wrt),
        .out_mem_rd(m_mem_rd), .out_mem_wr(m_mem_wr), .out_branch(m_branch),
        .out_jmp(m_jmp), .out_jmp_reg(m_jmp_reg), .out_alu_op(m_alu_op),
        .out_halt(m_halt), .out_err(m_err), .out_redirect(m_redirect),
        .out_redirect_pc(m_redirect_pc), .err_cnt(m_err_cnt), .state(m_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [4:0] op, input logic [15:0] pc);
        in_valid = 1'b1;
        in_instr = {op, 11'h0};
        in_pc    = pc;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        in_pc     = 16'h0;
        halt_ext  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_state", state, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // ADDI legal on default instance, illegal on masked instance
        offer(5'b01000, 16'h0010);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_reg_wrt", out_reg_wrt, 1);
        chk("addi_alu_op", out_alu_op, 5'b01000);
        chk("addi_err", out_err, 0);
        chk("mask_err", m_err, 1);
        chk("mask_reg_wrt", m_reg_wrt, 0);
        chk("mask_cnt1", m_err_cnt, 1);
        tick();
        chk("mask_cnt2", m_err_cnt, 2);
        tick();
        chk("mask_cnt3", m_err_cnt, 3);
        tick();
        chk("mask_cnt_sat", m_err_cnt, 3);
        chk("addi_errcnt", err_cnt, 0);

        // SIIC then RTI
        offer(5'b00010, 16'h0040);
        tick();
        chk("siic_redirect", out_redirect, 1);
        chk("siic_pc", out_redirect_pc, 16'h0002);
        chk("siic_state", state, 2'b01);
        offer(5'b00011, 16'h0050);
        tick();
        chk("rti_redirect", out_redirect, 1);
        chk("rti_pc", out_redirect_pc, 16'h0040);
        chk("rti_state", state, 2'b00);

        // RTI in RUN is illegal
        offer(5'b00011, 16'h0060);
        tick();
        chk("rti_run_err", out_err, 1);
        chk("rti_run_redirect", out_redirect, 0);
        chk("rti_run_state", state, 2'b00);
        chk("rti_run_errcnt", err_cnt, 1);

        // Decode spot checks
        offer(5'b10001, 16'h0);
        tick();
        chk("ld_mem_rd", out_mem_rd, 1);
        chk("ld_reg_wrt", out_reg_wrt, 1);
        chk("ld_mem_wr", out_mem_wr, 0);
        offer(5'b10000, 16'h0);
        tick();
        chk("st_mem_wr", out_mem_wr, 1);
        chk("st_reg_wrt", out_reg_wrt, 0);
        offer(5'b01100, 16'h0);
        tick();
        chk("br_branch", out_branch, 1);
        chk("br_reg_wrt", out_reg_wrt, 0);
        offer(5'b00111, 16'h0);
        tick();
        chk("jalr_jmp_reg", out_jmp_reg, 1);
        chk("jalr_reg_wrt", out_reg_wrt, 1);
        chk("jalr_jmp", out_jmp, 0);

        // SIIC while already in EXC is illegal
        offer(5'b00010, 16'h0070);
        tick();
        chk("siic2_state", state, 2'b01);
        offer(5'b00010, 16'h0080);
        tick();
        chk("siic_exc_err", out_err, 1);
        chk("siic_exc_redirect", out_redirect, 0);
        chk("siic_exc_state", state, 2'b01);
        chk("siic_exc_errcnt", err_cnt, 2);
        offer(5'b00011, 16'h0);
        tick();
        chk("rti2_pc", out_redirect_pc, 16'h0070);
        chk("rti2_state", state, 2'b00);

        // Flush drops offered instructions with no side effects
        offer(5'b00011, 16'h0);
        flush = 1'b1;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_errcnt", err_cnt, 2);
        offer(5'b00000, 16'h0);
        tick();
        chk("flush_halt_valid", out_valid, 0);
        chk("flush_halt_state", state, 2'b00);
        flush = 1'b0;
        tick();
        chk("halt_valid", out_valid, 1);
        chk("halt_flag", out_halt, 1);
        chk("halt_state", state, 2'b10);
        chk("halt_in_ready", in_ready, 0);
        offer(5'b01000, 16'h0);
        tick();
        chk("halted_valid", out_valid, 0);
        chk("halted_state", state, 2'b10);
        chk("halted_in_ready", in_ready, 0);

        // Only reset leaves HALTED
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("halt_rst_state", state, 2'b00);
        chk("halt_rst_errcnt", err_cnt, 0);
        rst_n = 1'b1;

        // Stall holds the bundle, then async reset mid-stall
        offer(5'b01000, 16'h0);
        tick();
        chk("stall_pre_valid", out_valid, 1);
        out_ready = 1'b0;
        offer(5'b10001, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_alu_op", out_alu_op, 5'b01000);
            chk("stall_mem_rd", out_mem_rd, 0);
            chk("stall_in_ready", in_ready, 0);
        end
        chk("stall_mask_cnt", m_err_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_reg_wrt", out_reg_wrt, 0);
        chk("arst_alu_op", out_alu_op, 0);
        chk("arst_mask_cnt", m_err_cnt, 0);
        chk("arst_mask_err", m_err, 0);
        chk("arst_state", state, 0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
